// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register and one-entry skid buffer.
// Owns the PC, drives a request/ready imem port and absorbs words returned under stall.
module fetch_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] NOP      = XLEN'(32'h0000_0013)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_flag,
  input  logic            branch_flag,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] if_inst,
  output logic [XLEN-1:0] if_pc,
  output logic            if_valid
);

  typedef enum logic [1:0] {
    ST_START    = 2'd0,
    ST_FETCH    = 2'd1,
    ST_BUFFERED = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] buf_inst_q, buf_inst_d;
  logic [XLEN-1:0] buf_pc_q, buf_pc_d;
  logic [XLEN-1:0] if_inst_d, if_pc_d;
  logic            if_valid_d;
  logic            imem_req_d;
  logic [XLEN-1:0] target_aligned;
  logic [XLEN-1:0] pc_inc;

  assign target_aligned = branch_target & ~XLEN'(3);
  assign pc_inc         = pc_q + XLEN'(4);
  assign imem_addr      = pc_q;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_START;
      pc_q       <= RESET_PC;
      buf_inst_q <= NOP;
      buf_pc_q   <= '0;
      if_inst    <= NOP;
      if_pc      <= '0;
      if_valid   <= 1'b0;
      imem_req   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      buf_inst_q <= buf_inst_d;
      buf_pc_q   <= buf_pc_d;
      if_inst    <= if_inst_d;
      if_pc      <= if_pc_d;
      if_valid   <= if_valid_d;
      imem_req   <= imem_req_d;
    end
  end

  // Next-state: a stalled return parks in the buffer; a flush always returns to FETCH
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_START:    state_d = ST_FETCH;
      ST_FETCH:    if (!branch_flag && imem_ready && stall_flag) state_d = ST_BUFFERED;
      ST_BUFFERED: if (branch_flag || !stall_flag) state_d = ST_FETCH;
      default:     state_d = ST_START;
    endcase
  end

  // Datapath next values; branch_flag wins over stall_flag everywhere
  always_comb begin
    pc_d       = pc_q;
    buf_inst_d = buf_inst_q;
    buf_pc_d   = buf_pc_q;
    if_inst_d  = if_inst;
    if_pc_d    = if_pc;
    if_valid_d = if_valid;
    case (state_q)
      ST_FETCH: begin
        if (branch_flag) begin
          pc_d       = target_aligned;
          if_inst_d  = NOP;
          if_valid_d = 1'b0;
        end else if (imem_ready) begin
          pc_d = pc_inc;
          if (stall_flag) begin
            buf_inst_d = imem_rdata;
            buf_pc_d   = pc_q;
          end else begin
            if_inst_d  = imem_rdata;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
          end
        end else if (!stall_flag) begin
          if_inst_d  = NOP;
          if_valid_d = 1'b0;
        end
      end
      ST_BUFFERED: begin
        if (branch_flag) begin
          pc_d       = target_aligned;
          if_inst_d  = NOP;
          if_valid_d = 1'b0;
        end else if (!stall_flag) begin
          if_inst_d  = buf_inst_q;
          if_pc_d    = buf_pc_q;
          if_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
    imem_req_d = (state_d == ST_FETCH);
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a scoreboard holds the expected IF/ID stream
// while the stimulus process also checks imem port and bubble behaviour.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall_flag = 1'b0;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_valid;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  logic        prev_v = 1'b0;
  logic [31:0] prev_pc = '0;
  logic [31:0] prev_inst = '0;

  fetch_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_flag   (stall_flag),
    .branch_flag  (branch_flag),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .if_inst      (if_inst),
    .if_pc        (if_pc),
    .if_valid     (if_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  assign imem_rdata = rd(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: each newly presented IF/ID instruction must be the next expected one
  always @(negedge clk) begin
    if (if_valid && (!prev_v || if_pc != prev_pc || if_inst != prev_inst)) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_extra: got pc %08h expected nothing at %0t", if_pc, $time);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("sb_pc", if_pc, e);
        check("sb_inst", if_inst, rd(e));
      end
    end
    prev_v    = if_valid;
    prev_pc   = if_pc;
    prev_inst = if_inst;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and straight-line fetch with imem_ready high
    #1 rst_n = 1'b0;
    imem_ready = 1'b1;
    repeat (2) step();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_inst", if_inst, NOP);
    check("rst_pc", if_pc, 32'h0);
    check("rst_valid", 32'(if_valid), 32'd0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    rst_n = 1'b1;
    step();
    check("start_req", 32'(imem_req), 32'd1);
    check("start_valid", 32'(if_valid), 32'd0);
    step();
    check("first_valid", 32'(if_valid), 32'd1);
    check("first_pc", if_pc, 32'h0);
    step();
    check("second_pc", if_pc, 32'h4);

    // Two wait states at 0x8
    imem_ready = 1'b0;
    step();
    check("wait1_addr", imem_addr, 32'h8);
    check("wait1_valid", 32'(if_valid), 32'd0);
    check("wait1_inst", if_inst, NOP);
    step();
    check("wait2_addr", imem_addr, 32'h8);
    check("wait2_valid", 32'(if_valid), 32'd0);
    imem_ready = 1'b1;
    step();
    check("after_wait_pc", if_pc, 32'h8);

    // Stall for 3 cycles while 0xC returns into the skid buffer
    exp_q.push_back(32'hC);
    exp_q.push_back(32'h10);
    stall_flag = 1'b1;
    step();
    check("stall1_req", 32'(imem_req), 32'd0);
    check("stall1_addr", imem_addr, 32'h10);
    check("stall1_pc", if_pc, 32'h8);
    step();
    check("stall2_pc", if_pc, 32'h8);
    check("stall2_req", 32'(imem_req), 32'd0);
    step();
    check("stall3_pc", if_pc, 32'h8);
    stall_flag = 1'b0;
    step();
    check("unstall_pc", if_pc, 32'hC);
    check("unstall_req", 32'(imem_req), 32'd1);
    check("unstall_addr", imem_addr, 32'h10);
    step();
    check("resume_pc", if_pc, 32'h10);

    // Branch to unaligned target on the same cycle imem returns 0x14
    exp_q.push_back(32'h100);
    branch_flag   = 1'b1;
    branch_target = 32'h103;
    step();
    check("br_valid", 32'(if_valid), 32'd0);
    check("br_inst", if_inst, NOP);
    check("br_addr", imem_addr, 32'h100);
    branch_flag = 1'b0;
    step();
    check("br_pc", if_pc, 32'h100);

    // Flush while BUFFERED and stalled: buffered 0x104 must never appear
    exp_q.push_back(32'h200);
    stall_flag = 1'b1;
    step();
    check("buf_req", 32'(imem_req), 32'd0);
    branch_flag   = 1'b1;
    branch_target = 32'h200;
    step();
    check("bflush_valid", 32'(if_valid), 32'd0);
    check("bflush_addr", imem_addr, 32'h200);
    check("bflush_req", 32'(imem_req), 32'd1);
    branch_flag = 1'b0;
    stall_flag  = 1'b0;
    step();
    check("bflush_pc", if_pc, 32'h200);

    // PC wraparound
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    branch_flag   = 1'b1;
    branch_target = 32'hFFFF_FFFF;
    step();
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    branch_flag = 1'b0;
    step();
    check("wrap_pc", if_pc, 32'hFFFF_FFFC);
    check("wrap_addr", imem_addr, 32'h0);
    step();
    check("wrap_next_pc", if_pc, 32'h0);
    imem_ready = 1'b0;
    step();
    check("mw_addr", imem_addr, 32'h4);

    // Reset pulsed mid-wait acts asynchronously
    #2 rst_n = 1'b0;
    #1;
    check("arst_req", 32'(imem_req), 32'd0);
    check("arst_addr", imem_addr, 32'h0);
    check("arst_valid", 32'(if_valid), 32'd0);
    check("arst_inst", if_inst, NOP);
    check("arst_pc", if_pc, 32'h0);
    step();
    exp_q.push_back(32'h0);
    imem_ready = 1'b1;
    rst_n = 1'b1;
    step();
    check("rs_req", 32'(imem_req), 32'd1);
    check("rs_addr", imem_addr, 32'h0);
    step();
    check("rs_pc", if_pc, 32'h0);
    check("rs_valid", 32'(if_valid), 32'd1);
    imem_ready = 1'b0;
    repeat (3) step();
    check("sb_left", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the 5-stage RISC-V core.
- Owns the PC and drives a request/ready instruction-memory port.
- Feeds `if_inst` and `if_pc` to the decode stage and to the data-hazard controller.
- Consumes the hazard controller's `stall_flag` and the EX-stage branch redirect; a one-entry skid buffer absorbs a word that returns while the stage is stalled.

Parameters:
- XLEN, 32, width of PC and instruction word.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP, 32'h0000_0013, bubble encoding (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- stall_flag  in  1  from hazard controller; hold IF/ID and PC.
- branch_flag  in  1  redirect/flush request from EX.
- branch_target  in  XLEN  redirect address.
- imem_req  out  1  fetch request, level.
- imem_addr  out  XLEN  fetch address; equals pc.
- imem_ready  in  1  imem_rdata valid this cycle; completes the request.
- imem_rdata  in  XLEN  fetched instruction.
- if_inst  out  XLEN  IF/ID instruction.
- if_pc  out  XLEN  IF/ID PC.
- if_valid  out  1  IF/ID holds a real instruction.

Behaviour:
Reset (async, rst_n=0):
- state=START, pc=RESET_PC, if_inst=NOP, if_pc=0, if_valid=0, buffer empty.
- imem_req=0.

Outputs:
- imem_req=1 only in FETCH; imem_addr=pc at all times.
- Address and request are held stable until imem_ready, unless a branch occurs.

States:
START:
- Exactly one cycle after reset release, then go to FETCH.
- IF/ID holds reset values.

FETCH, priority order:
- branch_flag: pc<=branch_target with bits[1:0] forced to 0; IF/ID <= bubble (NOP, if_valid=0). Any imem_ready this cycle is discarded. Stay in FETCH.
- imem_ready & !stall_flag: if_inst<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+4.
- imem_ready & stall_flag: buf_inst<=imem_rdata, buf_pc<=pc, pc<=pc+4, go to BUFFERED. IF/ID held.
- !imem_ready & stall_flag: everything held.
- !imem_ready & !stall_flag: IF/ID <= bubble; pc held.

BUFFERED (imem_req=0):
- branch_flag: drop buffer; pc<=target (aligned); IF/ID <= bubble; go to FETCH.
- !stall_flag: if_inst<=buf_inst, if_pc<=buf_pc, if_valid<=1; go to FETCH.
- stall_flag: hold.

General rules:
- branch_flag overrides stall_flag in every state.
- pc+4 wraps modulo 2^XLEN with no flag.
- Latency: an instruction appears on if_* the cycle after its imem_ready edge when not stalled.
- Peak throughput is one instruction per cycle with imem_ready tied high.
- A stalled IF/ID never changes except by branch flush.
- Reset asserted mid-request abandons the request immediately, with no handshake completion required.
- No instruction is lost or duplicated across any stall/branch sequence.

Test Plan:
1. Reset release, imem_ready=1 always, imem_rdata=addr-derived: imem_req rises 1 cycle after release. if_pc sequence 0,4,8,C on consecutive cycles, if_valid=1 from the 2nd fetch edge.
2. Memory wait states: imem_ready low for 2 cycles at addr 0x8. imem_addr is held at 0x8; if_valid=0 with if_inst=NOP for 2 cycles; then if_pc=0x8.
3. stall_flag high for 3 cycles while the word at 0xC returns:
   - IF/ID keeps 0x8 throughout.
   - imem_req drops while the buffer is full; imem_addr=0x10.
   - On stall release if_pc=0xC, then fetch resumes at 0x10 with no gap beyond the handshake.
4. branch_flag with target 0x103 in the same cycle as imem_ready at 0x14: the returned word is discarded, IF/ID gets a bubble, the next imem_addr is 0x100, and the next valid if_pc is 0x100.
5. branch_flag while BUFFERED with stall_flag high: the buffered word is never emitted, the flush wins over the stall, and fetch restarts at the target.
6. pc=0xFFFF_FFFC, fetch completes: next imem_addr=0x0. rst_n pulsed low mid-wait: outputs return to reset values asynchronously and restart at RESET_PC.
